tx_engine: RTL and testbench

Transmit-side descriptor engine for the e1000 datapath. Accepts local descriptor-RAM addresses of legacy TX descriptors, fetches each descriptor over AXI, DMAs the host buffer into a local packet ring via the iDMA, hands completed frames (EOP) to the frame transmit process, writes DD status back when RS is set, and reports completion per descriptor.

---
 rtl/e1000_pkg.sv | 34 +++
 rtl/tx_engine.sv | 274 +++++++++++++++++++++++++++
 tb/tb_tx_engine.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/e1000_pkg.sv
// Shared e1000 constants: legacy TX descriptor layout, command/status bits,
// AXI encodings and the TX engine state type.
package e1000_pkg;

    localparam int TXD_DW_BUF_LO = 0;
    localparam int TXD_DW_BUF_HI = 1;
    localparam int TXD_DW_LEN    = 2;
    localparam int TXD_DW_STA    = 3;
    localparam int TXD_CMD_LSB   = 24;

    localparam int CMD_EOP = 0;
    localparam int CMD_RS  = 3;
    localparam int STA_DD  = 0;

    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] TXD_BEATS_M1   = 8'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_D,
        ST_CHECK,
        ST_SPACE,
        ST_DMA_CMD,
        ST_DMA_WAIT,
        ST_FRAME,
        ST_WB_A,
        ST_WB_D,
        ST_WB_B,
        ST_REPORT
    } tx_state_e;

endpackage

// File: rtl/tx_engine.sv
// e1000 transmit descriptor engine: fetch descriptor, DMA buffer into the local
// packet ring, hand off EOP frames, write back DD on RS, report completion.
module tx_engine #(
    parameter logic [15:0] PKT_BUF_BASE = 16'h8000,
    parameter int unsigned PKT_BUF_SIZE = 32'h8000
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [31:0] cmd_s_tdata,
    input  logic        cmd_s_tvalid,
    input  logic        cmd_s_tlast,
    output logic        cmd_s_tready,

    output logic [31:0] stat_m_tdata,
    output logic        stat_m_tvalid,
    output logic        stat_m_tlast,
    input  logic        stat_m_tready,

    output logic [3:0]  ram_m_arid,
    output logic [15:0] ram_m_araddr,
    output logic [7:0]  ram_m_arlen,
    output logic [2:0]  ram_m_arsize,
    output logic [1:0]  ram_m_arburst,
    output logic        ram_m_arvalid,
    input  logic        ram_m_arready,
    input  logic [3:0]  ram_m_rid,
    input  logic [31:0] ram_m_rdata,
    input  logic [1:0]  ram_m_rresp,
    input  logic        ram_m_rlast,
    input  logic        ram_m_rvalid,
    output logic        ram_m_rready,
    output logic [3:0]  ram_m_awid,
    output logic [15:0] ram_m_awaddr,
    output logic [7:0]  ram_m_awlen,
    output logic [2:0]  ram_m_awsize,
    output logic [1:0]  ram_m_awburst,
    output logic        ram_m_awvalid,
    input  logic        ram_m_awready,
    output logic [3:0]  ram_m_wid,
    output logic [31:0] ram_m_wdata,
    output logic [3:0]  ram_m_wstrb,
    output logic        ram_m_wlast,
    output logic        ram_m_wvalid,
    input  logic        ram_m_wready,
    input  logic [3:0]  ram_m_bid,
    input  logic [1:0]  ram_m_bresp,
    input  logic        ram_m_bvalid,
    output logic        ram_m_bready,

    output logic [63:0] dma_src_addr,
    output logic [15:0] dma_dst_addr,
    output logic [15:0] dma_bytes,
    output logic        dma_valid,
    input  logic        dma_ready,

    input  logic [63:0] rpt_src_addr,
    input  logic [15:0] rpt_dst_addr,
    input  logic [15:0] rpt_bytes,
    input  logic        rpt_valid,
    output logic        rpt_ready,

    output logic [31:0] frm_m_tdata,
    output logic        frm_m_tvalid,
    output logic        frm_m_tlast,
    input  logic        frm_m_tready,

    input  logic [31:0] frm_s_tdata,
    input  logic        frm_s_tvalid,
    input  logic        frm_s_tlast,
    output logic        frm_s_tready
);
    import e1000_pkg::*;

    localparam logic [15:0] RING_MASK = 16'(PKT_BUF_SIZE - 1);
    localparam logic [16:0] FREE_INIT = 17'(PKT_BUF_SIZE);

    tx_state_e         state_q, state_d;
    logic [15:0]       desc_addr_q, desc_addr_d;
    logic [3:0][31:0]  dw_q, dw_d;
    logic [1:0]        beat_q, beat_d;
    logic [15:0]       wr_ptr_q, wr_ptr_d;
    logic [15:0]       frame_start_q, frame_start_d;
    logic [15:0]       frame_len_q, frame_len_d;
    logic [16:0]       free_q, free_d;
    logic              cmd_tready_q, cmd_tready_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              dma_valid_q, dma_valid_d;
    logic              frm_valid_q, frm_valid_d;
    logic              stat_valid_q, stat_valid_d;

    logic [63:0]       desc_buf;
    logic [15:0]       desc_len;
    logic              desc_eop, desc_rs;
    logic [15:0]       alloc;
    logic [16:0]       release_bytes;
    tx_state_e         after_data, after_frame;

    assign desc_buf = {dw_q[TXD_DW_BUF_HI], dw_q[TXD_DW_BUF_LO]};
    assign desc_len = dw_q[TXD_DW_LEN][15:0];
    assign desc_eop = dw_q[TXD_DW_LEN][TXD_CMD_LSB + CMD_EOP];
    assign desc_rs  = dw_q[TXD_DW_LEN][TXD_CMD_LSB + CMD_RS];

    // Non-EOP descriptors skip FRAME; RS clear skips the write-back.
    assign after_frame = desc_rs ? ST_WB_A : ST_REPORT;
    assign after_data  = desc_eop ? ST_FRAME : after_frame;

    // Transmitter releases are always accepted.
    assign release_bytes = frm_s_tvalid ? {1'b0, frm_s_tdata[15:0]} : 17'd0;

    always_comb begin
        state_d       = state_q;
        desc_addr_d   = desc_addr_q;
        dw_d          = dw_q;
        beat_d        = beat_q;
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        frame_len_d   = frame_len_q;
        alloc         = 16'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_tready_q && cmd_s_tvalid) begin
                    desc_addr_d = cmd_s_tdata[15:0];
                    state_d     = ST_FETCH_A;
                end
            end
            ST_FETCH_A: begin
                beat_d = 2'd0;
                if (arvalid_q && ram_m_arready) state_d = ST_FETCH_D;
            end
            ST_FETCH_D: begin
                if (ram_m_rvalid) begin
                    dw_d[beat_q] = ram_m_rdata;
                    beat_d       = beat_q + 2'd1;
                    if (ram_m_rlast) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (desc_buf == 64'd0 || desc_len == 16'd0) state_d = after_data;
                else                                        state_d = ST_SPACE;
            end
            ST_SPACE: begin
                if (free_q >= {1'b0, desc_len}) state_d = ST_DMA_CMD;
            end
            ST_DMA_CMD: begin
                if (dma_valid_q && dma_ready) begin
                    alloc       = desc_len;
                    wr_ptr_d    = (wr_ptr_q + desc_len) & RING_MASK;
                    frame_len_d = frame_len_q + desc_len;
                    state_d     = ST_DMA_WAIT;
                end
            end
            ST_DMA_WAIT: begin
                if (rpt_valid) state_d = after_data;
            end
            ST_FRAME: begin
                if (frm_valid_q && frm_m_tready) begin
                    frame_start_d = wr_ptr_q;
                    frame_len_d   = 16'd0;
                    state_d       = after_frame;
                end
            end
            ST_WB_A: begin
                if (awvalid_q && ram_m_awready) state_d = ST_WB_D;
            end
            ST_WB_D: begin
                if (wvalid_q && ram_m_wready) state_d = ST_WB_B;
            end
            ST_WB_B: begin
                if (ram_m_bvalid) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (stat_valid_q && stat_m_tready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Allocation and release in the same cycle net out.
        free_d = free_q - {1'b0, alloc} + release_bytes;

        // Every handshake leaves its state, so each valid is simply "next state is X".
        cmd_tready_d = (state_d == ST_IDLE);
        arvalid_d    = (state_d == ST_FETCH_A);
        dma_valid_d  = (state_d == ST_DMA_CMD);
        frm_valid_d  = (state_d == ST_FRAME);
        awvalid_d    = (state_d == ST_WB_A);
        wvalid_d     = (state_d == ST_WB_D);
        stat_valid_d = (state_d == ST_REPORT);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            desc_addr_q   <= '0;
            dw_q          <= '0;
            beat_q        <= '0;
            wr_ptr_q      <= '0;
            frame_start_q <= '0;
            frame_len_q   <= '0;
            free_q        <= FREE_INIT;
            cmd_tready_q  <= 1'b0;
            arvalid_q     <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            dma_valid_q   <= 1'b0;
            frm_valid_q   <= 1'b0;
            stat_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            desc_addr_q   <= desc_addr_d;
            dw_q          <= dw_d;
            beat_q        <= beat_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_start_q <= frame_start_d;
            frame_len_q   <= frame_len_d;
            free_q        <= free_d;
            cmd_tready_q  <= cmd_tready_d;
            arvalid_q     <= arvalid_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            dma_valid_q   <= dma_valid_d;
            frm_valid_q   <= frm_valid_d;
            stat_valid_q  <= stat_valid_d;
        end
    end

    assign cmd_s_tready  = cmd_tready_q;

    assign stat_m_tdata  = {16'd0, desc_addr_q};
    assign stat_m_tvalid = stat_valid_q;
    assign stat_m_tlast  = 1'b1;

    assign ram_m_arid    = 4'd0;
    assign ram_m_araddr  = desc_addr_q;
    assign ram_m_arlen   = TXD_BEATS_M1;
    assign ram_m_arsize  = AXI_SIZE_4B;
    assign ram_m_arburst = AXI_BURST_INCR;
    assign ram_m_arvalid = arvalid_q;
    assign ram_m_rready  = 1'b1;

    // Status dword sits at offset 0xC of the 16-byte descriptor.
    assign ram_m_awid    = 4'd0;
    assign ram_m_awaddr  = {desc_addr_q[15:4], 4'hC};
    assign ram_m_awlen   = 8'd0;
    assign ram_m_awsize  = AXI_SIZE_4B;
    assign ram_m_awburst = AXI_BURST_INCR;
    assign ram_m_awvalid = awvalid_q;
    assign ram_m_wid     = 4'd0;
    assign ram_m_wdata   = dw_q[TXD_DW_STA] | (32'd1 << STA_DD);
    assign ram_m_wstrb   = 4'hF;
    assign ram_m_wlast   = 1'b1;
    assign ram_m_wvalid  = wvalid_q;
    assign ram_m_bready  = 1'b1;

    assign dma_src_addr  = desc_buf;
    assign dma_dst_addr  = PKT_BUF_BASE + wr_ptr_q;
    assign dma_bytes     = desc_len;
    assign dma_valid     = dma_valid_q;
    assign rpt_ready     = 1'b1;

    assign frm_m_tdata   = {frame_len_q, PKT_BUF_BASE + frame_start_q};
    assign frm_m_tvalid  = frm_valid_q;
    assign frm_m_tlast   = 1'b1;
    assign frm_s_tready  = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{cmd_s_tdata[31:16], cmd_s_tlast, ram_m_rid, ram_m_rresp,
                         ram_m_bid, ram_m_bresp, rpt_src_addr, rpt_dst_addr,
                         rpt_bytes, frm_s_tdata[31:16], frm_s_tlast};

endmodule

// File: tb/tb_tx_engine.sv
// Directed bench for tx_engine with a 256-byte ring: descriptor RAM, iDMA and
// frame/status sinks are modelled here; results are logged and compared to constants.
module tb_tx_engine;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [31:0] cmd_s_tdata = '0;
    logic        cmd_s_tvalid = 1'b0, cmd_s_tlast = 1'b1, cmd_s_tready;
    logic [31:0] stat_m_tdata;
    logic        stat_m_tvalid, stat_m_tlast, stat_m_tready = 1'b1;
    logic [3:0]  arid, awid, wid, rid = '0, bid = '0;
    logic [15:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp = '0, bresp = '0;
    logic        arvalid, arready = 1'b1, rlast = 1'b0, rvalid = 1'b0, rready;
    logic        awvalid, awready = 1'b1, wlast, wvalid, wready = 1'b1;
    logic        bvalid = 1'b0, bready;
    logic [31:0] rdata = '0, wdata;
    logic [3:0]  wstrb;
    logic [63:0] dma_src_addr;
    logic [15:0] dma_dst_addr, dma_bytes;
    logic        dma_valid, dma_ready = 1'b1;
    logic [63:0] rpt_src_addr = '0;
    logic [15:0] rpt_dst_addr = '0, rpt_bytes = '0;
    logic        rpt_valid = 1'b0, rpt_ready;
    logic [31:0] frm_m_tdata;
    logic        frm_m_tvalid, frm_m_tlast, frm_m_tready = 1'b1;
    logic [31:0] frm_s_tdata = '0;
    logic        frm_s_tvalid = 1'b0, frm_s_tlast = 1'b1, frm_s_tready;

    tx_engine #(.PKT_BUF_BASE(16'h8000), .PKT_BUF_SIZE(256)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_s_tdata(cmd_s_tdata), .cmd_s_tvalid(cmd_s_tvalid), .cmd_s_tlast(cmd_s_tlast), .cmd_s_tready(cmd_s_tready),
        .stat_m_tdata(stat_m_tdata), .stat_m_tvalid(stat_m_tvalid), .stat_m_tlast(stat_m_tlast), .stat_m_tready(stat_m_tready),
        .ram_m_arid(arid), .ram_m_araddr(araddr), .ram_m_arlen(arlen), .ram_m_arsize(arsize), .ram_m_arburst(arburst),
        .ram_m_arvalid(arvalid), .ram_m_arready(arready),
        .ram_m_rid(rid), .ram_m_rdata(rdata), .ram_m_rresp(rresp), .ram_m_rlast(rlast), .ram_m_rvalid(rvalid), .ram_m_rready(rready),
        .ram_m_awid(awid), .ram_m_awaddr(awaddr), .ram_m_awlen(awlen), .ram_m_awsize(awsize), .ram_m_awburst(awburst),
        .ram_m_awvalid(awvalid), .ram_m_awready(awready),
        .ram_m_wid(wid), .ram_m_wdata(wdata), .ram_m_wstrb(wstrb), .ram_m_wlast(wlast), .ram_m_wvalid(wvalid), .ram_m_wready(wready),
        .ram_m_bid(bid), .ram_m_bresp(bresp), .ram_m_bvalid(bvalid), .ram_m_bready(bready),
        .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr), .dma_bytes(dma_bytes), .dma_valid(dma_valid), .dma_ready(dma_ready),
        .rpt_src_addr(rpt_src_addr), .rpt_dst_addr(rpt_dst_addr), .rpt_bytes(rpt_bytes), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .frm_m_tdata(frm_m_tdata), .frm_m_tvalid(frm_m_tvalid), .frm_m_tlast(frm_m_tlast), .frm_m_tready(frm_m_tready),
        .frm_s_tdata(frm_s_tdata), .frm_s_tvalid(frm_s_tvalid), .frm_s_tlast(frm_s_tlast), .frm_s_tready(frm_s_tready)
    );

    int n_chk = 0, n_err = 0;
    logic [31:0] mem [0:1023];
    logic [63:0] dma_src_q[$];
    logic [15:0] dma_dst_q[$], dma_len_q[$], wb_addr_q[$];
    logic [31:0] wb_data_q[$], frm_q[$], stat_q[$];
    int aw_cnt = 0;
    logic rpt_hold = 1'b0;

    // Descriptor RAM: zero-wait reads, beats start the cycle after AR.
    logic [15:0] rd_addr, wr_addr;
    int rd_left = 0;
    logic b_pend = 1'b0;
    always @(negedge aclk) begin
        if (!aresetn) begin
            rd_left = 0; rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0; b_pend = 1'b0;
        end else begin
            if (rd_left != 0) begin
                rvalid = 1'b1; rdata = mem[rd_addr[11:2]]; rlast = (rd_left == 1);
                rd_addr = rd_addr + 16'd4; rd_left--;
            end else begin
                rvalid = 1'b0; rlast = 1'b0;
            end
            if (arvalid && arready) begin rd_addr = araddr; rd_left = int'(arlen) + 1; end
            bvalid = b_pend; b_pend = 1'b0;
            if (awvalid && awready) begin wr_addr = awaddr; aw_cnt++; end
            if (wvalid && wready) begin wb_addr_q.push_back(wr_addr); wb_data_q.push_back(wdata); b_pend = 1'b1; end
        end
    end

    // iDMA: report three cycles after accept unless held.
    int dma_cnt = 0;
    always @(negedge aclk) begin
        rpt_valid = 1'b0;
        if (!aresetn) dma_cnt = 0;
        else begin
            if (dma_cnt != 0 && !(rpt_hold && dma_cnt == 1)) begin
                dma_cnt--;
                if (dma_cnt == 0) rpt_valid = 1'b1;
            end
            if (dma_valid && dma_ready) begin
                dma_src_q.push_back(dma_src_addr); dma_dst_q.push_back(dma_dst_addr);
                dma_len_q.push_back(dma_bytes); dma_cnt = 3;
            end
        end
    end

    always @(negedge aclk) begin
        if (frm_m_tvalid && frm_m_tready) frm_q.push_back(frm_m_tdata);
        if (stat_m_tvalid && stat_m_tready) stat_q.push_back(stat_m_tdata);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_cmd_tready"}, 64'(cmd_s_tready), 0);
        chk({tag, "_stat_tvalid"}, 64'(stat_m_tvalid), 0);
        chk({tag, "_stat_tlast"}, 64'(stat_m_tlast), 1);
        chk({tag, "_arvalid"}, 64'(arvalid), 0);
        chk({tag, "_awvalid"}, 64'(awvalid), 0);
        chk({tag, "_wvalid"}, 64'(wvalid), 0);
        chk({tag, "_ready1"}, 64'({bready, rready, wlast}), 64'h7);
        chk({tag, "_dma_valid"}, 64'(dma_valid), 0);
        chk({tag, "_frm_tvalid"}, 64'(frm_m_tvalid), 0);
        chk({tag, "_frm_tlast"}, 64'(frm_m_tlast), 1);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        #1 chk_rst("rst");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic put_desc(input logic [15:0] a, input logic [63:0] bufa,
                            input logic [15:0] len, input logic [7:0] cmd, input logic [31:0] sta);
        mem[a[11:2]]     = bufa[31:0];
        mem[a[11:2] + 1] = bufa[63:32];
        mem[a[11:2] + 2] = {cmd, 8'h00, len};
        mem[a[11:2] + 3] = sta;
    endtask

    task automatic send_cmd(input logic [15:0] a);
        int n = 0;
        @(negedge aclk);
        cmd_s_tdata = {16'hABCD, a};
        cmd_s_tvalid = 1'b1;
        while (!cmd_s_tready && n < 500) begin @(negedge aclk); n++; end
        chk("cmd_accept_timeout", 64'(n < 500), 1);
        @(negedge aclk);
        cmd_s_tvalid = 1'b0;
    endtask

    task automatic wait_stat(input string tag, input int n);
        int c = 0;
        while (stat_q.size() < n && c < 500) begin @(negedge aclk); c++; end
        chk(tag, 64'(stat_q.size()), 64'(n));
    endtask

    initial begin
        int bd, bf, bw, bs, ba;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #1 chk_rst("por");
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // Single EOP|RS descriptor.
        do_reset();
        bd = dma_dst_q.size(); bf = frm_q.size(); bw = wb_addr_q.size(); bs = stat_q.size();
        put_desc(16'h0100, 64'h1_0000_2000, 16'd64, 8'h09, 32'h0);
        send_cmd(16'h0100);
        wait_stat("t1_stat_cnt", bs + 1);
        chk("t1_dma_src", dma_src_q[bd], 64'h1_0000_2000);
        chk("t1_dma_dst", 64'(dma_dst_q[bd]), 64'h8000);
        chk("t1_dma_len", 64'(dma_len_q[bd]), 64'd64);
        chk("t1_frm", 64'(frm_q[bf]), 64'h0040_8000);
        chk("t1_wb_addr", 64'(wb_addr_q[bw]), 64'h010C);
        chk("t1_wb_data", 64'(wb_data_q[bw]), 64'h1);
        chk("t1_stat", 64'(stat_q[bs]), 64'h0000_0100);

        // Non-EOP then EOP, RS clear: one combined frame, no write-back.
        do_reset();
        bd = dma_dst_q.size(); bf = frm_q.size(); bs = stat_q.size(); ba = aw_cnt;
        put_desc(16'h0200, 64'h3000, 16'd100, 8'h00, 32'h0);
        put_desc(16'h0210, 64'h4000, 16'd28, 8'h01, 32'h0);
        send_cmd(16'h0200);
        wait_stat("t2_stat_cnt_a", bs + 1);
        chk("t2_no_frame_yet", 64'(frm_q.size()), 64'(bf));
        send_cmd(16'h0210);
        wait_stat("t2_stat_cnt_b", bs + 2);
        chk("t2_dst0", 64'(dma_dst_q[bd]), 64'h8000);
        chk("t2_dst1", 64'(dma_dst_q[bd + 1]), 64'h8064);
        chk("t2_frm_cnt", 64'(frm_q.size()), 64'(bf + 1));
        chk("t2_frm", 64'(frm_q[bf]), 64'h0080_8000);
        chk("t2_no_aw", 64'(aw_cnt), 64'(ba));
        chk("t2_stat1", 64'(stat_q[bs + 1]), 64'h0000_0210);

        // Ring full stall, release, wrap.
        do_reset();
        bd = dma_dst_q.size(); bf = frm_q.size(); bs = stat_q.size();
        put_desc(16'h0300, 64'h5000, 16'd100, 8'h01, 32'h0);
        put_desc(16'h0310, 64'h5100, 16'd100, 8'h01, 32'h0);
        put_desc(16'h0320, 64'h5200, 16'd100, 8'h01, 32'h0);
        put_desc(16'h0330, 64'h5300, 16'd16, 8'h01, 32'h0);
        send_cmd(16'h0300);
        send_cmd(16'h0310);
        wait_stat("t3_stat_cnt_2", bs + 2);
        send_cmd(16'h0320);
        repeat (40) @(negedge aclk);
        chk("t3_stall_dma", 64'(dma_dst_q.size()), 64'(bd + 2));
        chk("t3_stall_stat", 64'(stat_q.size()), 64'(bs + 2));
        frm_s_tdata = 32'd100; frm_s_tvalid = 1'b1;
        @(negedge aclk);
        frm_s_tvalid = 1'b0; frm_s_tdata = '0;
        wait_stat("t3_stat_cnt_3", bs + 3);
        chk("t3_dst2", 64'(dma_dst_q[bd + 2]), 64'h80C8);
        chk("t3_frm1", 64'(frm_q[bf + 1]), 64'h0064_8064);
        chk("t3_frm2", 64'(frm_q[bf + 2]), 64'h0064_80C8);
        send_cmd(16'h0330);
        wait_stat("t3_stat_cnt_4", bs + 4);
        chk("t3_wrap_dst", 64'(dma_dst_q[bd + 3]), 64'h802C);
        chk("t3_wrap_frm", 64'(frm_q[bf + 3]), 64'h0010_802C);

        // Null buffer address with RS: no DMA/frame, DD still written back.
        bd = dma_dst_q.size(); bf = frm_q.size(); bw = wb_addr_q.size(); bs = stat_q.size();
        put_desc(16'h0400, 64'h0, 16'd32, 8'h08, 32'h0000_0010);
        send_cmd(16'h0400);
        wait_stat("t4_stat_cnt", bs + 1);
        chk("t4_no_dma", 64'(dma_dst_q.size()), 64'(bd));
        chk("t4_no_frm", 64'(frm_q.size()), 64'(bf));
        chk("t4_wb_addr", 64'(wb_addr_q[bw]), 64'h040C);
        chk("t4_wb_data", 64'(wb_data_q[bw]), 64'h11);
        chk("t4_stat", 64'(stat_q[bs]), 64'h0000_0400);

        // Reset while waiting on the iDMA report.
        do_reset();
        bd = dma_dst_q.size(); bs = stat_q.size();
        put_desc(16'h0600, 64'h7000, 16'd48, 8'h01, 32'h0);
        put_desc(16'h0500, 64'h6000, 16'd48, 8'h01, 32'h0);
        put_desc(16'h0510, 64'h6100, 16'd16, 8'h01, 32'h0);
        send_cmd(16'h0600);
        wait_stat("t5_stat_cnt_a", bs + 1);
        rpt_hold = 1'b1;
        send_cmd(16'h0500);
        for (int c = 0; c < 200 && dma_dst_q.size() < bd + 2; c++) @(negedge aclk);
        repeat (3) @(negedge aclk);
        chk("t5_hold_dst", 64'(dma_dst_q[bd + 1]), 64'h8030);
        chk("t5_hold_stat", 64'(stat_q.size()), 64'(bs + 1));
        aresetn = 1'b0;
        #1 chk_rst("midrst");
        @(negedge aclk);
        aresetn = 1'b1;
        rpt_hold = 1'b0;
        bd = dma_dst_q.size(); bf = frm_q.size(); bs = stat_q.size();
        send_cmd(16'h0510);
        wait_stat("t5_stat_cnt_b", bs + 1);
        chk("t5_dst_after_rst", 64'(dma_dst_q[bd]), 64'h8000);
        chk("t5_frm_after_rst", 64'(frm_q[bf]), 64'h0010_8000);
        chk("t5_stat", 64'(stat_q[bs]), 64'h0000_0510);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
